codec_slave_port: RTL and testbench

Synthesizable CODEC-side serial port that responds to the I2S-style master in the equalizer's codec interface. It follows externally driven SCLK and LRCLK, deserializes SDin into left/right 16-bit words and serializes supplied left/right words onto SDout. It is used as the CODEC stand-in for board bring-up loopback and as the DUT-side CODEC model in full-chip benches. Everything runs on the 50 MHz system clock; SCLK and LRCLK are sampled, never used as clocks.

---
 rtl/codec_slave_port.sv | 209 ++++++++++++++++++++
 tb/tb_codec_slave_port.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/codec_slave_port.sv
// rtl/codec_slave_port.sv - I2S-style CODEC slave port sampled on the system clock
//
// Follows an externally driven SCLK/LRCLK pair and works only in the clk domain.
// Incoming bits on SDin are collected into left/right words. The shadowed
// transmit words are shifted out on SDout. SCLK, LRCLK and SDin are never used
// as clocks.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   RSTn            CODEC reset from the master, active low, synchronous hold-idle
//   SCLK, LRCLK     bit clock and frame clock from the master (LRCLK low = left)
//   SDin / SDout    serial data in / out, MSB first, change on SCLK fall
//   rx_lft, rx_rht  last complete received left/right pair
//   rx_vld          one-clk pulse when rx_lft/rx_rht are updated
//   tx_lft, tx_rht  words to transmit, captured at each accepted LRCLK fall
//   tx_ld           one-clk pulse when the transmit words are captured
//   frm_err         one-clk pulse when a slot ends early
//   lpbk            (CODEC_SLAVE_LOOPBACK_EN only) capture rx words for transmit
//
// Optional feature macro: CODEC_SLAVE_LOOPBACK_EN

module codec_slave_port #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RSTn,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              SDin,
    output logic              SDout,
    output logic [DATA_W-1:0] rx_lft,
    output logic [DATA_W-1:0] rx_rht,
    output logic              rx_vld,
    input  logic [DATA_W-1:0] tx_lft,
    input  logic [DATA_W-1:0] tx_rht,
`ifdef CODEC_SLAVE_LOOPBACK_EN
    input  logic              lpbk,
`endif
    output logic              tx_ld,
    output logic              frm_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TX_DONE  = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE, L_DLY, L_SHIFT, L_PAD, R_DLY, R_SHIFT, R_PAD
    } state_t;

    // Synchronizers: identical depth keeps SCLK/LRCLK/SDin alignment intact.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] lrclk_sync_q;
    logic [SYNC_STAGES-1:0] sdin_sync_q;
    logic                   sclk_prev_q;
    logic                   lrclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            lrclk_sync_q <= '1;   // idle-high LRCLK must not look like a fall
            sdin_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            lrclk_prev_q <= 1'b1;
        end else begin
            sclk_sync_q[0]  <= SCLK;
            lrclk_sync_q[0] <= LRCLK;
            sdin_sync_q[0]  <= SDin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i]  <= sclk_sync_q[i-1];
                lrclk_sync_q[i] <= lrclk_sync_q[i-1];
                sdin_sync_q[i]  <= sdin_sync_q[i-1];
            end
            sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
            lrclk_prev_q <= lrclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, lrclk_s, sd_s;
    logic sclk_rise, sclk_fall, lr_rise, lr_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign lrclk_s   = lrclk_sync_q[SYNC_STAGES-1];
    assign sd_s      = sdin_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign lr_rise   = lrclk_s & ~lrclk_prev_q;
    assign lr_fall   = ~lrclk_s & lrclk_prev_q;

    // Transmit capture source.
    logic [DATA_W-1:0] cap_l, cap_r;
`ifdef CODEC_SLAVE_LOOPBACK_EN
    assign cap_l = lpbk ? rx_lft : tx_lft;
    assign cap_r = lpbk ? rx_rht : tx_rht;
`else
    assign cap_l = tx_lft;
    assign cap_r = tx_rht;
`endif

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] lft_hold_q;
    logic              lft_ok_q;     // a full left word has arrived this frame
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] tx_r_sh_q;
    logic              in_slot;

    // Slot states in which an LRCLK edge means the slot was cut short.
    assign in_slot = (state_q == L_DLY) || (state_q == L_SHIFT) ||
                     (state_q == R_DLY) || (state_q == R_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_cnt_q   <= TX_DONE;
            rx_sh_q    <= '0;
            lft_hold_q <= '0;
            lft_ok_q   <= 1'b0;
            tx_sh_q    <= '0;
            tx_r_sh_q  <= '0;
            rx_lft     <= '0;
            rx_rht     <= '0;
            rx_vld     <= 1'b0;
            tx_ld      <= 1'b0;
            frm_err    <= 1'b0;
            SDout      <= 1'b0;
        end else begin
            rx_vld  <= 1'b0;
            tx_ld   <= 1'b0;
            frm_err <= 1'b0;
            if (!RSTn) begin
                // rx_lft/rx_rht intentionally keep their last values here.
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                tx_cnt_q  <= TX_DONE;
                lft_ok_q  <= 1'b0;
                SDout     <= 1'b0;
            end else if (lr_fall) begin
                // Start of a left slot; any SCLK fall this cycle is the delay bit.
                frm_err   <= in_slot;
                state_q   <= L_DLY;
                bit_cnt_q <= '0;
                lft_ok_q  <= 1'b0;
                tx_sh_q   <= cap_l;
                tx_r_sh_q <= cap_r;
                tx_ld     <= 1'b1;
                tx_cnt_q  <= '0;
                SDout     <= 1'b0;
            end else if (lr_rise && state_q != IDLE) begin
                frm_err   <= in_slot;
                state_q   <= R_DLY;
                bit_cnt_q <= '0;
                tx_sh_q   <= tx_r_sh_q;
                tx_cnt_q  <= '0;
                SDout     <= 1'b0;
            end else begin
                if (state_q != IDLE && sclk_fall) begin
                    if (tx_cnt_q != TX_DONE) begin
                        SDout    <= tx_sh_q[DATA_W-1];
                        tx_sh_q  <= {tx_sh_q[DATA_W-2:0], 1'b0};
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end else begin
                        SDout <= 1'b0;
                    end
                end
                if (sclk_rise) begin
                    case (state_q)
                        L_DLY: state_q <= L_SHIFT;
                        R_DLY: state_q <= R_SHIFT;
                        L_SHIFT: begin
                            rx_sh_q <= {rx_sh_q[DATA_W-2:0], sd_s};
                            if (bit_cnt_q == BIT_LAST) begin
                                lft_hold_q <= {rx_sh_q[DATA_W-2:0], sd_s};
                                lft_ok_q   <= 1'b1;
                                bit_cnt_q  <= '0;
                                state_q    <= L_PAD;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        R_SHIFT: begin
                            rx_sh_q <= {rx_sh_q[DATA_W-2:0], sd_s};
                            if (bit_cnt_q == BIT_LAST) begin
                                // Publish only a pair whose left half was complete.
                                if (lft_ok_q) begin
                                    rx_lft <= lft_hold_q;
                                    rx_rht <= {rx_sh_q[DATA_W-2:0], sd_s};
                                    rx_vld <= 1'b1;
                                end
                                lft_ok_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= R_PAD;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_slave_port.sv
// tb/tb_codec_slave_port.sv - self-checking bench for codec_slave_port
module tb_codec_slave_port;

    localparam int W    = 16;
    localparam int HALF = 16;   // SCLK = clk/32
    localparam int SLOT = 32;   // SCLK periods per slot

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic         rst_n, RSTn, SCLK, LRCLK, SDin, SDout;
    logic [W-1:0] rx_lft, rx_rht, tx_lft, tx_rht;
    logic         rx_vld, tx_ld, frm_err;
`ifdef CODEC_SLAVE_LOOPBACK_EN
    logic         lpbk;
`endif

    codec_slave_port #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .RSTn(RSTn), .SCLK(SCLK), .LRCLK(LRCLK),
        .SDin(SDin), .SDout(SDout), .rx_lft(rx_lft), .rx_rht(rx_rht),
        .rx_vld(rx_vld), .tx_lft(tx_lft), .tx_rht(tx_rht),
`ifdef CODEC_SLAVE_LOOPBACK_EN
        .lpbk(lpbk),
`endif
        .tx_ld(tx_ld), .frm_err(frm_err)
    );

    int total = 0;
    int bad   = 0;
    int n_vld = 0, n_ld = 0, n_err = 0;

    always @(negedge clk) begin
        if (rx_vld)  n_vld++;
        if (tx_ld)   n_ld++;
        if (frm_err) n_err++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Master: one frame, left slot lbits SCLK periods, right slot SLOT periods.
    // SDout is sampled at each SCLK rise; non-data positions must be 0.
    task automatic run_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lbits,
                             output logic [W-1:0] gl, output logic [W-1:0] gr, output int padbad);
        int n;
        logic [W-1:0] w;
        gl = '0; gr = '0; padbad = 0;
        for (int s = 0; s < 2; s++) begin
            n = (s == 0) ? lbits : SLOT;
            w = (s == 0) ? l : r;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                SCLK = 1'b0;
                if (k == 0) LRCLK = (s == 1);
                SDin = (k >= 1 && k <= W) ? w[W-k] : 1'b0;
                repeat (HALF) @(negedge clk);
                SCLK = 1'b1;
                if (k >= 1 && k <= W) begin
                    if (s == 0) gl[W-k] = SDout;
                    else        gr[W-k] = SDout;
                end else if (SDout !== 1'b0) begin
                    padbad++;
                end
                repeat (HALF - 1) @(negedge clk);
            end
        end
    endtask

    typedef struct {
        int           lbits;
        logic [W-1:0] l, r;       // master sends
        logic [W-1:0] tl, tr;     // tx inputs
        logic [W-1:0] xl, xr;     // expected rx_lft/rx_rht after frame
        logic [W-1:0] xsl, xsr;   // expected SDout words
        int           xvld, xerr;
        bit           chkl;
    } vec_t;

    vec_t vt[5];

    logic [W-1:0] gl, gr;
    int pb, v0, l0, e0;

    task automatic frame_checks(input string tag, input int xvld, input int xerr,
                                input logic [W-1:0] xl, input logic [W-1:0] xr);
        check({tag, " rx_vld count"}, 64'(n_vld - v0), 64'(xvld));
        check({tag, " tx_ld count"},  64'(n_ld - l0),  64'd1);
        check({tag, " frm_err count"}, 64'(n_err - e0), 64'(xerr));
        check({tag, " rx_lft"}, 64'(rx_lft), 64'(xl));
        check({tag, " rx_rht"}, 64'(rx_rht), 64'(xr));
    endtask

    initial begin
        vt[0] = '{32, 16'hA55A, 16'h1234, 16'h8001, 16'h7FFE, 16'hA55A, 16'h1234, 16'h8001, 16'h7FFE, 1, 0, 1'b1};
        vt[1] = '{32, 16'h0F0F, 16'hF0F0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'hF0F0, 16'hFFFF, 16'h0000, 1, 0, 1'b1};
        vt[2] = '{10, 16'h5555, 16'hAAAA, 16'h1357, 16'h2468, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, 0, 1, 1'b0};
        vt[3] = '{32, 16'h00FF, 16'hFF00, 16'h0001, 16'h8000, 16'h00FF, 16'hFF00, 16'h0001, 16'h8000, 1, 0, 1'b1};
        vt[4] = '{32, 16'hFFFF, 16'h0001, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001, 16'hA5A5, 16'h5A5A, 1, 0, 1'b1};

        rst_n = 1'b0; RSTn = 1'b1; SCLK = 1'b1; LRCLK = 1'b1; SDin = 1'b0;
        tx_lft = '0; tx_rht = '0;
`ifdef CODEC_SLAVE_LOOPBACK_EN
        lpbk = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("reset outputs", {26'd0, SDout, rx_vld, tx_ld, frm_err, rx_lft, rx_rht}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            tx_lft = vt[i].tl; tx_rht = vt[i].tr;
            v0 = n_vld; l0 = n_ld; e0 = n_err;
            run_frame(vt[i].l, vt[i].r, vt[i].lbits, gl, gr, pb);
            frame_checks($sformatf("vec%0d", i), vt[i].xvld, vt[i].xerr, vt[i].xl, vt[i].xr);
            if (vt[i].chkl) check($sformatf("vec%0d sdout left", i), 64'(gl), 64'(vt[i].xsl));
            check($sformatf("vec%0d sdout right", i), 64'(gr), 64'(vt[i].xsr));
            check($sformatf("vec%0d sdout pad", i), 64'(pb), 64'd0);
        end

        // RSTn low for 200 clks inside the right slot: no rx_vld, SDout 0, rx held.
        tx_lft = 16'hC3C3; tx_rht = 16'h3C3C;
        v0 = n_vld; l0 = n_ld; e0 = n_err;
        fork
            run_frame(16'h1357, 16'h2468, 32, gl, gr, pb);
            begin
                repeat (1324) @(negedge clk);
                RSTn = 1'b0;
                repeat (100) @(negedge clk);
                check("RSTn low sdout", 64'(SDout), 64'd0);
                repeat (100) @(negedge clk);
                RSTn = 1'b1;
            end
        join
        frame_checks("rstn frame", 0, 0, 16'hFFFF, 16'h0001);

        tx_lft = 16'h00F0; tx_rht = 16'h0F00;
        v0 = n_vld; l0 = n_ld; e0 = n_err;
        run_frame(16'hBEEF, 16'hCAFE, 32, gl, gr, pb);
        frame_checks("rstn recover", 1, 0, 16'hBEEF, 16'hCAFE);
        check("rstn recover sdout", {32'd0, gl, gr}, {32'd0, 16'h00F0, 16'h0F00});

        // rst_n mid left shift: outputs clear immediately.
        fork
            run_frame(16'h1111, 16'h2222, 32, gl, gr, pb);
            begin
                repeat (400) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("rst_n async clear", {26'd0, SDout, rx_vld, tx_ld, frm_err, rx_lft, rx_rht}, 64'd0);
                repeat (20) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        tx_lft = 16'h6006; tx_rht = 16'h0660;
        v0 = n_vld; l0 = n_ld; e0 = n_err;
        run_frame(16'h7E81, 16'h817E, 32, gl, gr, pb);
        frame_checks("rst_n recover", 1, 0, 16'h7E81, 16'h817E);
        check("rst_n recover sdout", {32'd0, gl, gr}, {32'd0, 16'h6006, 16'h0660});

        // tx_rht changed mid-frame: right slot still sends the word captured at LRCLK fall.
        tx_lft = 16'h1111; tx_rht = 16'h2222;
        v0 = n_vld; l0 = n_ld; e0 = n_err;
        fork
            run_frame(16'h4242, 16'h2424, 32, gl, gr, pb);
            begin
                repeat (500) @(negedge clk);
                tx_rht = 16'hDEAD;
            end
        join
        frame_checks("shadow frame", 1, 0, 16'h4242, 16'h2424);
        check("shadow sdout", {32'd0, gl, gr}, {32'd0, 16'h1111, 16'h2222});

`ifdef CODEC_SLAVE_LOOPBACK_EN
        lpbk = 1'b1;
        run_frame(16'h0F0F, 16'hF0F0, 32, gl, gr, pb);
        v0 = n_vld; l0 = n_ld; e0 = n_err;
        run_frame(16'h0000, 16'h0000, 32, gl, gr, pb);
        check("loopback sdout", {32'd0, gl, gr}, {32'd0, 16'h0F0F, 16'hF0F0});
        check("loopback tx_ld", 64'(n_ld - l0), 64'd1);
        lpbk = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
